// File: rtl/jtag_cmd_sync.sv
//============================================================================
// Module  : jtag_cmd_sync
// Brief   : TCK->clk strobe sync, jdo capture, one-hot action decode and
//           command FIFO. Optional parity check: define JCS_PARITY_EN.
// Revision: 1.0
//============================================================================
`default_nettype none

module jtag_cmd_sync #(
  parameter int IR_WIDTH    = 2,
  parameter int DATA_WIDTH  = 38,
  parameter int SYNC_STAGES = 2,
  parameter int ACTION_BIT  = 35,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [DATA_WIDTH-1:0]         sr,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  output logic [DATA_WIDTH-1:0]         jdo,
  output logic [2**IR_WIDTH-1:0]        take_action,
  output logic [2**IR_WIDTH-1:0]        take_no_action,
  output logic                          uir_pulse,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [IR_WIDTH-1:0]           cmd_ir,
  output logic [DATA_WIDTH-1:0]         cmd_data,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          parity_err
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_EW = IR_WIDTH + DATA_WIDTH;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] r_udr_sync, r_uir_sync;
  logic                   r_udr_last, r_uir_last;
  logic                   w_udr_rise, w_uir_rise;
  logic [IR_WIDTH-1:0]    r_ir_cap;
  logic                   r_cap;
  logic                   r_par_ok;
  logic                   w_par_ok;

  assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_last;
  assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync <= '0;
      r_uir_sync <= '0;
      r_udr_last <= 1'b0;
      r_uir_last <= 1'b0;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_last <= r_udr_sync[SYNC_STAGES-1];
      r_uir_last <= r_uir_sync[SYNC_STAGES-1];
    end
  end

`ifdef JCS_PARITY_EN
  // MSB carries even parity over the rest of the scan.
  assign w_par_ok = ~(^sr);
`else
  assign w_par_ok = 1'b1;
`endif

  // sr/ir_in are quiet while vs_udr is high, so sampling them here is safe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir_cap <= '0;
      jdo      <= '0;
      r_cap    <= 1'b0;
      r_par_ok <= 1'b0;
    end else begin
      r_cap <= w_udr_rise;
      if (w_udr_rise) begin
        r_ir_cap <= ir_in;
        jdo      <= sr;
        r_par_ok <= w_par_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      take_action    <= '0;
      take_no_action <= '0;
      uir_pulse      <= 1'b0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      uir_pulse      <= w_uir_rise;
      if (r_cap && r_par_ok) begin
        if (jdo[ACTION_BIT]) take_action[r_ir_cap]    <= 1'b1;
        else                 take_no_action[r_ir_cap] <= 1'b1;
      end
    end
  end

`ifdef JCS_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity_err <= 1'b0;
    else          parity_err <= r_cap & ~r_par_ok;
  end
`else
  assign parity_err = 1'b0;
`endif

  logic [c_EW-1:0] r_mem [FIFO_DEPTH];
  logic [c_PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_PW-1:0] w_rd_next;
  logic [c_CW-1:0] w_after_pop;
  logic [c_EW-1:0] w_entry, w_head_next;
  logic            w_push, w_pop, w_full, w_accept, w_drop;

  assign cmd_valid   = (cmd_count != '0);
  assign w_full      = (cmd_count == c_FULL);
  assign w_push      = r_cap & r_par_ok;
  assign w_pop       = cmd_valid & cmd_ready;
  assign w_accept    = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;
  assign w_entry     = {r_ir_cap, jdo};
  assign w_rd_next   = r_rd_ptr + c_PW'(w_pop);
  assign w_after_pop = cmd_count - c_CW'(w_pop);
  // A push into an effectively empty queue becomes the head directly.
  assign w_head_next = (w_after_pop == '0) ? w_entry : r_mem[w_rd_next];

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      cmd_count <= '0;
      cmd_ir    <= '0;
      cmd_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      r_rd_ptr  <= w_rd_next;
      r_wr_ptr  <= r_wr_ptr + c_PW'(w_accept);
      cmd_count <= w_after_pop + c_CW'(w_accept);
      if (w_pop || (w_accept && (w_after_pop == '0)))
        {cmd_ir, cmd_data} <= w_head_next;
      if (w_drop)            overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtag_cmd_sync.sv
//============================================================================
// Module  : tb_jtag_cmd_sync
// Brief   : Scoreboard bench for jtag_cmd_sync (directed scans, FIFO limits).
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_jtag_cmd_sync;

  localparam int IRW = 2;
  localparam int DW  = 38;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [IRW-1:0] ir_in;
  logic [DW-1:0] sr;
  logic          vs_udr, vs_uir;
  logic [DW-1:0] jdo;
  logic [3:0]    take_action, take_no_action;
  logic          uir_pulse, cmd_valid, cmd_ready;
  logic [IRW-1:0] cmd_ir;
  logic [DW-1:0] cmd_data;
  logic [2:0]    cmd_count;
  logic          overflow, overflow_clr, parity_err;

  jtag_cmd_sync #(
    .IR_WIDTH(2), .DATA_WIDTH(38), .SYNC_STAGES(2), .ACTION_BIT(35), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .uir_pulse(uir_pulse), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .overflow(overflow), .overflow_clr(overflow_clr), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  logic [7:0]  q_pulse[$];
  logic [39:0] q_cmd[$];
  int n_total = 0;
  int n_bad   = 0;
  int n_pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_pulse(input logic [1:0] ir, input logic [DW-1:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << ir;
    return d[35] ? {oh, 4'b0000} : {4'b0000, oh};
  endfunction

  function automatic logic [DW-1:0] pf(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef JCS_PARITY_EN
    r[DW-1] = ^r[DW-2:0];
`endif
    return r;
  endfunction

  // Monitor: compares pulses and popped head entries against the queues.
  always @(negedge clk) begin
    if (!reset_n) begin
      if ((|take_action) || (|take_no_action) || uir_pulse)
        chk("pulse_in_reset", {take_action, take_no_action, uir_pulse}, 0);
    end else begin
      if ((|take_action) || (|take_no_action)) begin
        n_pulses++;
        if (q_pulse.size() == 0) chk("unexpected_pulse", {take_action, take_no_action}, 0);
        else chk("action_pulse", {take_action, take_no_action}, q_pulse.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
        if (q_cmd.size() == 0) chk("unexpected_cmd", 1, 0);
        else chk("cmd_head", {cmd_ir, cmd_data}, q_cmd.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [1:0] ir, input logic [DW-1:0] d, input bit push);
    ir_in  = ir;
    sr     = d;
    vs_udr = 1'b1;
    q_pulse.push_back(exp_pulse(ir, d));
    if (push) q_cmd.push_back({ir, d});
  endtask

  task automatic end_scan(input int hold);
    repeat (hold) cyc();
    vs_udr = 1'b0;
    repeat (5) cyc();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_jdo"}, jdo, 0);
    chk({name, "_pulses"}, {take_action, take_no_action, uir_pulse, parity_err}, 0);
    chk({name, "_fifo"}, {cmd_valid, cmd_count, overflow, cmd_ir, cmd_data}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d, da, db, last;
    int p0;
    reset_n = 1'b0; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
    cmd_ready = 1'b0; overflow_clr = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk_all_zero("reset");
    cyc();
    reset_n = 1'b1;
    repeat (2) cyc();

    // Scan with action bit set, latency of jdo
    da = pf(38'h2A_1234_5678);
    start_scan(2'd2, da, 1'b1);
    cyc(); cyc();
    @(negedge clk); chk("jdo_before_latency", jdo, 0);
    cyc();
    @(negedge clk); chk("jdo_latency3", jdo, da);
    end_scan(1);
    chk("t1_valid", cmd_valid, 1);
    chk("t1_ir", cmd_ir, 2);
    chk("t1_data", cmd_data, da);
    chk("t1_count", cmd_count, 1);

    // No-action scan with a long-held strobe
    db = pf(38'h01_0000_00AB);
    p0 = n_pulses;
    start_scan(2'd1, db, 1'b1);
    end_scan(20);
    chk("held_strobe_one_pulse", n_pulses - p0, 1);
    chk("t2_count", cmd_count, 2);
    cmd_ready = 1'b1;
    repeat (2) cyc();
    cmd_ready = 1'b0;
    @(negedge clk);
    chk("t2_drained", {cmd_valid, cmd_count}, 0);

    // Five scans into a 4-deep queue: last one dropped
    for (int i = 0; i < 5; i++) begin
      d = pf({(i % 2) ? 6'h08 : 6'h00, 32'hC0DE_0000 + 32'(i)});
      start_scan(2'(i), d, i < 4);
      end_scan(4);
    end
    @(negedge clk);
    chk("t3_count_full", cmd_count, 4);
    chk("t3_overflow", overflow, 1);
    chk("t3_head", {cmd_ir, cmd_data}, {2'd0, pf({6'h00, 32'hC0DE_0000})});
    cmd_ready = 1'b1;
    repeat (4) cyc();
    cmd_ready = 1'b0;
    @(negedge clk);
    chk("t3_drained", {cmd_valid, cmd_count}, 0);
    chk("t3_overflow_sticky", overflow, 1);
    overflow_clr = 1'b1;
    cyc();
    overflow_clr = 1'b0;
    @(negedge clk);
    chk("t3_overflow_clr", overflow, 0);

    // Full queue, push and pop on the same edge
    for (int i = 0; i < 4; i++) begin
      start_scan(2'd3, pf({6'h08, 32'hF00D_0000 + 32'(i)}), 1'b1);
      end_scan(4);
    end
    last = pf({6'h00, 32'hF00D_0004});
    start_scan(2'd0, last, 1'b1);
    repeat (3) cyc();
    cmd_ready = 1'b1;
    cyc();
    cmd_ready = 1'b0;
    @(negedge clk);
    chk("t4_count_stays_full", cmd_count, 4);
    chk("t4_no_overflow", overflow, 0);
    end_scan(0);
    cmd_ready = 1'b1;
    repeat (4) cyc();
    cmd_ready = 1'b0;
    @(negedge clk);
    chk("t4_drained", {cmd_valid, cmd_count}, 0);

    // Update-IR strobe
    vs_uir = 1'b1;
    cyc(); cyc();
    @(negedge clk); chk("uir_early", uir_pulse, 0);
    cyc();
    @(negedge clk); chk("uir_pulse", uir_pulse, 1);
    cyc();
    @(negedge clk); chk("uir_one_cycle", uir_pulse, 0);
    vs_uir = 1'b0;
    repeat (4) cyc();
    chk("uir_jdo_kept", jdo, last);
    chk("uir_count_kept", cmd_count, 0);

    // Async reset in the middle of a scan that stays high through release
    start_scan(2'd3, pf(38'h08_AAAA_5555), 1'b1);
    end_scan(4);
    chk("t6_count_before", cmd_count, 1);
    d = pf(38'h00_1357_9BDF);
    ir_in = 2'd0; sr = d; vs_udr = 1'b1;
    cyc();
    #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    q_cmd.delete();
    q_pulse.delete();
    q_pulse.push_back(exp_pulse(2'd0, d));
    q_cmd.push_back({2'd0, d});
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (8) cyc();
    vs_udr = 1'b0;
    repeat (5) cyc();
    chk("t6_count_after", cmd_count, 1);
    cmd_ready = 1'b1;
    repeat (2) cyc();
    cmd_ready = 1'b0;

`ifdef JCS_PARITY_EN
    d = pf(38'h08_2468_ACE0);
    d[DW-1] = ~d[DW-1];
    ir_in = 2'd1; sr = d; vs_udr = 1'b1;
    repeat (4) cyc();
    @(negedge clk); chk("parity_err_pulse", parity_err, 1);
    cyc();
    @(negedge clk); chk("parity_err_one_cycle", parity_err, 0);
    vs_udr = 1'b0;
    repeat (5) cyc();
    chk("parity_jdo", jdo, d);
    chk("parity_no_push", cmd_count, 0);
    start_scan(2'd1, pf(38'h08_2468_ACE1), 1'b1);
    end_scan(4);
    chk("parity_good_push", cmd_count, 1);
    cmd_ready = 1'b1;
    repeat (2) cyc();
    cmd_ready = 1'b0;
`endif

    repeat (2) cyc();
    chk("pulse_queue_empty", q_pulse.size(), 0);
    chk("cmd_queue_empty", q_cmd.size(), 0);
`ifdef JCS_PARITY_EN
    chk("pulse_total", n_pulses, 15);
`else
    chk("pulse_total", n_pulses, 14);
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jtag_cmd_sync.md
Name: jtag_cmd_sync

Overview:
Parametrised successor to the sysclk half of the Nios II JTAG debug path. It brings TCK-domain virtual-JTAG update strobes into the system clock domain, latches the scanned shift register, and decodes the instruction into one-hot action and no-action pulses. It also queues each completed scan as a command in a FIFO with a valid/ready handshake, so the CPU-side consumer cannot lose back-to-back scans. It sits between the TCK-domain shift logic and the OCI/break/trace consumers.

Parameters:
IR_WIDTH, 2, virtual IR width; number of action channels is 2**IR_WIDTH
DATA_WIDTH, 38, shift-register / jdo width
SYNC_STAGES, 2, synchroniser depth for vs_udr/vs_uir (legal range 2..4)
ACTION_BIT, 35, index in sr selecting take_action (1) vs take_no_action (0)
FIFO_DEPTH, 4, command queue depth (power of 2, >= 2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ir_in  in  IR_WIDTH  virtual IR, TCK domain, stable while vs_udr is high
sr  in  DATA_WIDTH  shift register, TCK domain, stable while vs_udr is high
vs_udr  in  1  update-DR state, TCK domain
vs_uir  in  1  update-IR state, TCK domain
jdo  out  DATA_WIDTH  last captured sr
take_action  out  2**IR_WIDTH  one-hot 1-cycle pulse, index = captured IR
take_no_action  out  2**IR_WIDTH  one-hot 1-cycle pulse, index = captured IR
uir_pulse  out  1  1-cycle pulse per update-IR
cmd_valid  out  1  FIFO non-empty
cmd_ready  in  1  consumer accepts head entry
cmd_ir  out  IR_WIDTH  head entry IR
cmd_data  out  DATA_WIDTH  head entry data
cmd_count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: a push was dropped
overflow_clr  in  1  clears overflow
parity_err  out  1  1-cycle pulse; 0 when JCS_PARITY_EN is undefined

Behaviour:
- Reset (async, reset_n=0): all synchroniser flops, edge registers, jdo, pulses, FIFO pointers, count, overflow and parity_err go to 0. cmd_valid=0. Release is synchronous to clk through the flop chain.
- Synchroniser: vs_udr and vs_uir each pass through SYNC_STAGES flops plus one edge register. A rising edge of the last stage gives an internal udr_rise/uir_rise for exactly 1 cycle. A held-high strobe gives one pulse only.
- udr_rise cycle: register ir_in→ir_cap and sr→jdo at the next edge. Latency from the first sampling edge to the jdo update is SYNC_STAGES+1 clk cycles.
- The cycle after capture: take_action[ir_cap]=1 if jdo[ACTION_BIT]=1; otherwise take_no_action[ir_cap]=1. All other bits are 0. At most one bit of the two vectors is high in any cycle.
- uir_pulse asserts the cycle after uir_rise. It does not push to the FIFO and does not change jdo.
- Push: on the capture cycle, push {ir_cap, jdo} into the FIFO.
- FIFO:
  - cmd_valid = (count != 0); cmd_ir/cmd_data show the head entry.
  - Pop happens when cmd_valid && cmd_ready. Head outputs are registered from storage and change the cycle after a pop.
  - Push when full with no pop in the same cycle: the entry is dropped, overflow is set, and count is unchanged.
  - Push when full with a pop in the same cycle: both succeed, count stays at FIFO_DEPTH, overflow is not set.
  - Push when empty with cmd_ready=1: the entry appears with cmd_valid=1 the next cycle; there is no fall-through.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow_clr: clears overflow. If overflow_clr and a new overflow occur in the same cycle, set wins.
- Action pulses still fire when the FIFO is full; the drop only affects the queue.
- Reset mid-scan: a strobe still high after reset release produces one pulse once it passes through the synchroniser. There is no spurious pulse while reset is held.

Optional Feature:
JCS_PARITY_EN
- Defined: sr[DATA_WIDTH-1] is even parity over sr[DATA_WIDTH-2:0]. On a mismatch at capture:
  - jdo still updates;
  - no take_action or take_no_action pulse fires;
  - no FIFO push occurs;
  - parity_err pulses for 1 cycle, aligned to where the action pulse would have been.
- Undefined: no check is made; parity_err is tied to 0 and the MSB is ordinary data.

Test Plan:
- Reset, then vs_udr high with ir_in=2, sr[35]=1, sr=38'h2A_1234_5678 (default params) -> jdo=38'h2A_1234_5678 after 3 clk; take_action=4'b0100 for 1 cycle; cmd_valid=1 with cmd_ir=2; cmd_count=1.
- ir_in=1, sr[35]=0 -> take_no_action=4'b0010 for 1 cycle; take_action stays 0; vs_udr held high 20 cycles gives exactly 1 pulse.
- cmd_ready=0, 5 scans with FIFO_DEPTH=4 -> cmd_count=4, overflow=1, head equals scan 1. Pop 4 times -> scans 1..4 in order, then cmd_valid=0. overflow_clr -> overflow=0.
- FIFO full, push and pop in the same cycle -> cmd_count stays 4 and overflow stays 0.
- vs_uir pulse -> uir_pulse for 1 cycle; jdo and cmd_count unchanged. Assert reset_n=0 mid-sequence -> all outputs 0 immediately (async).
- With JCS_PARITY_EN, a scan with a bad parity MSB -> parity_err pulse, no action pulse, cmd_count unchanged. A good-parity scan -> normal action pulse and push.
